// File: rtl/avalon_wt_cache_pkg.sv
// Shared types and defaults for the write-through cache between the CPU Avalon
// master and main memory.
package avalon_wt_cache_pkg;

  localparam int CACHE_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } cache_state_t;

endpackage

// File: rtl/avalon_wt_cache_store.sv
// Line storage: valid/tag/data per one-word line, combinational read port and a
// byte-masked write port that also installs the tag and sets valid.
module avalon_wt_cache_store
  import avalon_wt_cache_pkg::*;
#(
  parameter  int IDX_W = CACHE_IDX_W,
  localparam int TAG_W = 30 - IDX_W,
  localparam int LINES = 2 ** IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be
);

  logic [LINES-1:0]            valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [LINES-1:0][31:0]      data_q, data_d;

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // A write-hit rewrites the same tag, so one port serves both fill and merge.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/avalon_wt_cache.sv
// Direct-mapped, write-through, no-write-allocate cache. Read hits answer with
// zero wait states; misses and every write go to RAM.
module avalon_wt_cache
  import avalon_wt_cache_pkg::*;
#(
  parameter int IDX_W = CACHE_IDX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  s_address,
  input  logic         s_read,
  input  logic         s_write,
  input  logic [31:0]  s_writedata,
  input  logic [3:0]   s_byteenable,
  output logic         s_waitrequest,
  output logic [31:0]  s_readdata,
  output logic [31:0]  m_address,
  output logic         m_read,
  output logic         m_write,
  output logic [31:0]  m_writedata,
  output logic [3:0]   m_byteenable,
  input  logic         m_waitrequest,
  input  logic [31:0]  m_readdata,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output cache_state_t dbg_state
);

  // Both sides use Avalon valid/ready: a request is held while waitrequest=1
  // and completes in the cycle it is sampled with waitrequest=0.
  localparam int TAG_W = 30 - IDX_W;

  cache_state_t     state_q, state_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      hit_cnt_q, hit_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [31:0]      line_data;
  logic             hit;
  logic             st_we;
  logic [31:0]      st_data;
  logic [3:0]       st_be;
  logic             addr_lsb_unused;

  assign idx             = s_address[IDX_W+1:2];
  assign tag             = s_address[31:IDX_W+2];
  assign hit             = line_valid && (line_tag == tag);
  assign addr_lsb_unused = ^s_address[1:0];

  assign m_address    = {s_address[31:2], 2'b00};
  assign m_writedata  = s_writedata;
  assign m_byteenable = (state_q == WRITE) ? s_byteenable : 4'b1111;
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    s_waitrequest = 1'b0;
    s_readdata    = rdata_q;
    m_read        = 1'b0;
    m_write       = 1'b0;
    st_we         = 1'b0;
    st_data       = m_readdata;
    st_be         = 4'b1111;
    unique case (state_q)
      IDLE: begin
        if (s_write) begin
          s_waitrequest = 1'b1;
          state_d       = WRITE;
        end else if (s_read) begin
          if (hit) begin
            s_readdata = line_data;
            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            s_waitrequest = 1'b1;
            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        s_waitrequest = 1'b1;
        m_read        = 1'b1;
        if (!m_waitrequest) begin
          st_we   = 1'b1;
          rdata_d = m_readdata;
          state_d = RESP;
        end
      end
      WRITE: begin
        s_waitrequest = 1'b1;
        m_write       = 1'b1;
        st_data       = s_writedata;
        st_be         = s_byteenable;
        if (!m_waitrequest) begin
          st_we   = hit;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  avalon_wt_cache_store #(.IDX_W(IDX_W)) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (st_we && !reset),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (st_data),
    .wr_be    (st_be)
  );

endmodule

// File: tb/tb_avalon_wt_cache.sv
// Directed bench for avalon_wt_cache: a vector table of CPU accesses against a
// small RAM responder, plus hand sequences for reset state and reset mid-fill.
module tb_avalon_wt_cache;
  import avalon_wt_cache_pkg::*;

  logic         clk;
  logic         reset;
  logic [31:0]  s_address;
  logic         s_read;
  logic         s_write;
  logic [31:0]  s_writedata;
  logic [3:0]   s_byteenable;
  logic         s_waitrequest;
  logic [31:0]  s_readdata;
  logic [31:0]  m_address;
  logic         m_read;
  logic         m_write;
  logic [31:0]  m_writedata;
  logic [3:0]   m_byteenable;
  logic         m_waitrequest;
  logic [31:0]  m_readdata;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  cache_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [logic [31:0]];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    bit          exp_hit;
    logic [31:0] exp_rdata;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  vec_t vecs [13];

  avalon_wt_cache dut (
    .clk           (clk),
    .reset         (reset),
    .s_address     (s_address),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_waitrequest (s_waitrequest),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  task automatic ram_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = ram_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ram[a] = w;
  endtask

  // driver: one CPU access, with the RAM side answering after v.waits stalls
  task automatic do_access(input int n, input vec_t v);
    int          wait_cyc, m_cyc, wcnt;
    bit          done, seen_m;
    logic [31:0] rdata, seen_addr;
    logic [3:0]  seen_be;
    wait_cyc = 0; m_cyc = 0; wcnt = 0; done = 0; seen_m = 0;
    rdata = '0; seen_addr = '0; seen_be = '0;
    @(negedge clk);
    s_address    = v.addr;
    s_writedata  = v.wdata;
    s_byteenable = v.be;
    s_write      = v.wr;
    s_read       = !v.wr;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (m_read || m_write) begin
        m_cyc++;
        seen_m    = 1;
        seen_addr = m_address;
        seen_be   = m_byteenable;
        m_waitrequest = (wcnt < v.waits);
        wcnt++;
        m_readdata = ram_rd(m_address);
        if (m_write && !m_waitrequest) ram_wr(m_address, m_writedata, m_byteenable);
      end else begin
        m_waitrequest = 1'b0;
      end
      #1;
      if (s_waitrequest) wait_cyc++;
      else begin
        done  = 1;
        rdata = s_readdata;
      end
      if (!done) @(negedge clk);
    end
    if (!done) chk($sformatf("v%0d_timeout", n), 32'd0, 32'd1);
    chk($sformatf("v%0d_wait_cycles", n), wait_cyc, v.exp_hit ? 0 : v.waits + 2);
    chk($sformatf("v%0d_ram_cycles", n), m_cyc, v.exp_hit ? 0 : v.waits + 1);
    if (!v.wr) chk($sformatf("v%0d_readdata", n), rdata, v.exp_rdata);
    if (seen_m) begin
      chk($sformatf("v%0d_m_address", n), seen_addr, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d_m_byteenable", n), {28'd0, seen_be}, v.wr ? {28'd0, v.be} : 32'hF);
    end
    @(negedge clk);
    s_read = 1'b0;
    s_write = 1'b0;
    m_waitrequest = 1'b0;
    #1;
    chk($sformatf("v%0d_hit_count", n), hit_count, v.exp_hits);
    chk($sformatf("v%0d_miss_count", n), miss_count, v.exp_misses);
    chk($sformatf("v%0d_idle_bus", n), {30'd0, m_read, m_write}, 32'd0);
  endtask

  initial begin
    // wr addr wdata be waits hit rdata hits misses
    vecs[0]  = '{0, 32'h1000, 32'h0, 4'hF, 2, 0, 32'hDEADBEEF, 0, 1};
    vecs[1]  = '{0, 32'h1000, 32'h0, 4'hF, 0, 1, 32'hDEADBEEF, 1, 1};
    vecs[2]  = '{1, 32'h1000, 32'h000000AA, 4'b0001, 1, 0, 32'h0, 1, 1};
    vecs[3]  = '{0, 32'h1000, 32'h0, 4'hF, 0, 1, 32'hDEADBEAA, 2, 1};
    vecs[4]  = '{1, 32'h2004, 32'h11223344, 4'hF, 0, 0, 32'h0, 2, 1};
    vecs[5]  = '{0, 32'h2004, 32'h0, 4'hF, 0, 0, 32'h11223344, 2, 2};
    vecs[6]  = '{0, 32'h2004, 32'h0, 4'hF, 0, 1, 32'h11223344, 3, 2};
    vecs[7]  = '{0, 32'h1040, 32'h0, 4'hF, 1, 0, 32'hCAFEF00D, 3, 3};
    vecs[8]  = '{0, 32'h1000, 32'h0, 4'hF, 0, 0, 32'hDEADBEAA, 3, 4};
    vecs[9]  = '{0, 32'h1000, 32'h0, 4'hF, 0, 1, 32'hDEADBEAA, 4, 4};
    vecs[10] = '{1, 32'h1000, 32'hFF00FF00, 4'b1010, 3, 0, 32'h0, 4, 4};
    vecs[11] = '{0, 32'h1000, 32'h0, 4'hF, 0, 1, 32'hFFADFFAA, 5, 4};
    vecs[12] = '{0, 32'h1003, 32'h0, 4'hF, 0, 1, 32'hFFADFFAA, 6, 4};

    ram[32'h1000] = 32'hDEADBEEF;
    ram[32'h2004] = 32'h12345678;
    ram[32'h1040] = 32'hCAFEF00D;

    reset = 1'b1;
    s_address = '0; s_read = 0; s_write = 0; s_writedata = '0; s_byteenable = '0;
    m_waitrequest = 1'b0; m_readdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    chk("reset_waitrequest", {31'd0, s_waitrequest}, 32'd0);
    chk("reset_m_rw", {30'd0, m_read, m_write}, 32'd0);
    chk("reset_readdata", s_readdata, 32'd0);
    chk("reset_hit_count", hit_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);

    for (int i = 0; i < 13; i++) do_access(i, vecs[i]);

    // reset in the middle of a fill that RAM keeps stalling
    @(negedge clk);
    s_address = 32'h1080; s_read = 1'b1; m_waitrequest = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("midfill_state", 32'(dbg_state), 32'(FILL));
    chk("midfill_m_read", {31'd0, m_read}, 32'd1);
    chk("midfill_m_address", m_address, 32'h1080);
    chk("midfill_waitrequest", {31'd0, s_waitrequest}, 32'd1);
    @(negedge clk);
    reset = 1'b1; s_read = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_fill_m_read", {31'd0, m_read}, 32'd0);
    chk("rst_fill_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_fill_waitrequest", {31'd0, s_waitrequest}, 32'd0);
    reset = 1'b0; m_waitrequest = 1'b0;
    do_access(100, '{0, 32'h1000, 32'h0, 4'hF, 0, 0, 32'hFFADFFAA, 0, 1});
    do_access(101, '{0, 32'h1000, 32'h0, 4'hF, 0, 1, 32'hFFADFFAA, 1, 1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
